// File: rtl/popcount_decoder.sv
// Decodes a 3-bit ones-count (0..4) into a 4-bit word with exactly that many ones, registered, valid/ready on both sides.
// Optional macro POPCOUNT_DECODER_ROTATE_EN rotates the thermometer by a running pointer to spread ones across bit lanes.
module popcount_decoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [2:0]           Count,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [3:0]           Pattern,
  output logic                 Error,
  output logic [ERR_CNT_W-1:0] ErrCount
);

  logic       accept;
  logic       illegal;
  logic [3:0] therm;
  logic [3:0] dec;

  // Pass-through backpressure: a draining slot can be refilled on the same edge.
  assign InReady = ~Reset & (~OutValid | OutReady);
  assign accept  = InValid & InReady;
  assign illegal = Count[2] & (|Count[1:0]);

  // Illegal counts fall into the default and decode to all zeros.
  always_comb begin
    therm = 4'b0000;
    case (Count)
      3'd1:    therm = 4'b0001;
      3'd2:    therm = 4'b0011;
      3'd3:    therm = 4'b0111;
      3'd4:    therm = 4'b1111;
      default: therm = 4'b0000;
    endcase
  end

`ifdef POPCOUNT_DECODER_ROTATE_EN
  logic [1:0] ptr;

  always_comb begin
    dec = therm;
    case (ptr)
      2'd0:    dec = therm;
      2'd1:    dec = {therm[2:0], therm[3]};
      2'd2:    dec = {therm[1:0], therm[3:2]};
      default: dec = {therm[0], therm[3:1]};
    endcase
  end

  // Advancing by count mod 4 keeps the next word starting just past the last one written.
  always_ff @(posedge Clock) begin
    if (Reset)                  ptr <= 2'd0;
    else if (accept & ~illegal) ptr <= ptr + Count[1:0];
  end
`else
  assign dec = therm;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      OutValid <= 1'b0;
      Pattern  <= 4'b0000;
      Error    <= 1'b0;
      ErrCount <= '0;
    end else if (accept) begin
      OutValid <= 1'b1;
      Pattern  <= dec;
      Error    <= illegal;
      if (illegal && (ErrCount != '1)) ErrCount <= ErrCount + ERR_CNT_W'(1);
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_popcount_decoder.sv
// Randomized and directed bench for popcount_decoder against a behavioural model of the ones-count rules.
module tb_popcount_decoder;

  localparam int ERR_CNT_W = 2;
  localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

  logic                 Clock, Reset, InValid, OutReady;
  logic                 InReady, OutValid, Error;
  logic [2:0]           Count;
  logic [3:0]           Pattern;
  logic [ERR_CNT_W-1:0] ErrCount;

  int errors = 0;
  int checks = 0;

  // Model state
  bit         m_ov;
  logic [3:0] m_pat;
  bit         m_err;
  int         m_ec;
  int         m_ptr;

  popcount_decoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Count(Count), .OutValid(OutValid), .OutReady(OutReady),
    .Pattern(Pattern), .Error(Error), .ErrCount(ErrCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Place c ones at consecutive positions starting at bit p, wrapping.
  function automatic logic [3:0] expand(int c, int p);
    logic [3:0] r;
    r = 4'b0000;
    for (int k = 0; k < c; k++) r[(p + k) % 4] = 1'b1;
    return r;
  endfunction

  function automatic int ones(logic [3:0] v);
    int n;
    n = 0;
    for (int k = 0; k < 4; k++) n += int'(v[k]);
    return n;
  endfunction

  function automatic bit exp_ready();
    return !Reset && (!m_ov || OutReady);
  endfunction

  task automatic tick();
    bit acc;
    int c;
    @(posedge Clock);
    c = int'(Count);
    if (Reset) begin
      m_ov = 0; m_pat = 4'b0000; m_err = 0; m_ec = 0; m_ptr = 0;
    end else begin
      acc = InValid && (!m_ov || OutReady);
      if (acc) begin
        m_ov = 1;
        if (c > 4) begin
          m_pat = 4'b0000;
          m_err = 1;
          if (m_ec < ERR_MAX) m_ec++;
        end else begin
          m_pat = expand(c, m_ptr);
          m_err = 0;
`ifdef POPCOUNT_DECODER_ROTATE_EN
          m_ptr = (m_ptr + c) % 4;
`endif
        end
      end else if (OutReady) begin
        m_ov = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    Reset = 1; InValid = 0; OutReady = 1; Count = 3'd0;
    tick();
    Reset = 0;
  endtask

  task automatic test_reset();
    Reset = 1; InValid = 1; Count = 3'd3; OutReady = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (InReady !== 1'b0) begin errors++; $display("FAIL reset_inready cyc=%0d got=%b exp=0", i, InReady); end
      tick();
    end
    Reset = 0;
    #1;
    checks++;
    if (OutValid !== 1'b0 || Pattern !== 4'b0000 || Error !== 1'b0 || ErrCount !== '0) begin
      errors++;
      $display("FAIL reset_values got ov=%b pat=%b err=%b ec=%0d exp ov=0 pat=0000 err=0 ec=0", OutValid, Pattern, Error, ErrCount);
    end
    checks++;
    if (InReady !== 1'b1) begin errors++; $display("FAIL post_reset_inready got=%b exp=1", InReady); end
    tick();
    checks++;
    if (OutValid !== 1'b1 || Pattern !== 4'b0111) begin
      errors++; $display("FAIL first_accept got ov=%b pat=%b exp ov=1 pat=0111", OutValid, Pattern);
    end
    InValid = 0;
    tick();
  endtask

  task automatic test_sweep();
    logic [3:0] tbl [5];
    tbl[0] = 4'b0000; tbl[1] = 4'b0001; tbl[2] = 4'b0011; tbl[3] = 4'b0111; tbl[4] = 4'b1111;
    do_reset();
    OutReady = 1; InValid = 1;
    for (int c = 0; c < 5; c++) begin
      Count = 3'(c);
      #1;
      checks++;
      if (InReady !== 1'b1) begin errors++; $display("FAIL sweep_ready c=%0d got=%b exp=1", c, InReady); end
      tick();
      checks++;
      if (OutValid !== 1'b1 || Pattern !== m_pat || Error !== 1'b0) begin
        errors++; $display("FAIL sweep c=%0d got ov=%b pat=%b err=%b exp ov=1 pat=%b err=0", c, OutValid, Pattern, Error, m_pat);
      end
`ifndef POPCOUNT_DECODER_ROTATE_EN
      checks++;
      if (Pattern !== tbl[c]) begin errors++; $display("FAIL sweep_therm c=%0d got=%b exp=%b", c, Pattern, tbl[c]); end
`endif
    end
    InValid = 0;
    tick();
  endtask

  task automatic test_rotation();
    int         cs  [4];
    logic [3:0] exp [4];
    cs[0] = 1; cs[1] = 2; cs[2] = 3; cs[3] = 1;
`ifdef POPCOUNT_DECODER_ROTATE_EN
    exp[0] = 4'b0001; exp[1] = 4'b0110; exp[2] = 4'b1011; exp[3] = 4'b0100;
`else
    exp[0] = 4'b0001; exp[1] = 4'b0011; exp[2] = 4'b0111; exp[3] = 4'b0001;
`endif
    do_reset();
    InValid = 1; OutReady = 1;
    for (int i = 0; i < 4; i++) begin
      Count = 3'(cs[i]);
      tick();
      checks++;
      if (Pattern !== exp[i] || OutValid !== 1'b1) begin
        errors++; $display("FAIL rotation i=%0d got ov=%b pat=%b exp ov=1 pat=%b", i, OutValid, Pattern, exp[i]);
      end
    end
    InValid = 0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    InValid = 1; OutReady = 1; Count = 3'd2;
    tick();
    Count = 3'd1; OutReady = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (InReady !== 1'b0) begin errors++; $display("FAIL bp_ready i=%0d got=%b exp=0", i, InReady); end
      tick();
      checks++;
      if (OutValid !== 1'b1 || Pattern !== 4'b0011 || Error !== 1'b0) begin
        errors++; $display("FAIL bp_hold i=%0d got ov=%b pat=%b exp ov=1 pat=0011", i, OutValid, Pattern);
      end
    end
    OutReady = 1;
    #1;
    checks++;
    if (InReady !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", InReady); end
    tick();
    checks++;
    if (OutValid !== 1'b1 || Pattern !== m_pat) begin
      errors++; $display("FAIL bp_next got ov=%b pat=%b exp ov=1 pat=%b", OutValid, Pattern, m_pat);
    end
`ifndef POPCOUNT_DECODER_ROTATE_EN
    checks++;
    if (Pattern !== 4'b0001) begin errors++; $display("FAIL bp_next_therm got=%b exp=0001", Pattern); end
`endif
    InValid = 0;
    tick();
    checks++;
    if (OutValid !== 1'b0 || Pattern !== m_pat) begin
      errors++; $display("FAIL bp_drain got ov=%b pat=%b exp ov=0 pat=%b", OutValid, Pattern, m_pat);
    end
  endtask

  task automatic test_illegal();
    int cs [5];
    int ec [5];
    cs[0] = 5; cs[1] = 6; cs[2] = 7; cs[3] = 5; cs[4] = 7;
    ec[0] = 1; ec[1] = 2; ec[2] = 3; ec[3] = 3; ec[4] = 3;
    do_reset();
    InValid = 1; OutReady = 1;
    for (int i = 0; i < 5; i++) begin
      Count = 3'(cs[i]);
      tick();
      checks++;
      if (Pattern !== 4'b0000 || Error !== 1'b1 || int'(ErrCount) != ec[i]) begin
        errors++; $display("FAIL illegal i=%0d got pat=%b err=%b ec=%0d exp pat=0000 err=1 ec=%0d", i, Pattern, Error, ErrCount, ec[i]);
      end
    end
    Count = 3'd1;
    tick();
    checks++;
    if (Pattern !== 4'b0001 || Error !== 1'b0 || int'(ErrCount) != 3) begin
      errors++; $display("FAIL illegal_recover got pat=%b err=%b ec=%0d exp pat=0001 err=0 ec=3", Pattern, Error, ErrCount);
    end
    InValid = 0;
    tick();
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    InValid = 1; OutReady = 1; Count = 3'd5;
    tick();
    InValid = 1; OutReady = 0; Count = 3'd2;
    tick();
    Reset = 1;
    tick();
    Reset = 0; InValid = 0; OutReady = 1;
    #1;
    checks++;
    if (OutValid !== 1'b0 || ErrCount !== '0 || Pattern !== 4'b0000 || Error !== 1'b0) begin
      errors++; $display("FAIL mid_reset got ov=%b ec=%0d pat=%b err=%b exp ov=0 ec=0 pat=0000 err=0", OutValid, ErrCount, Pattern, Error);
    end
    InValid = 1; Count = 3'd1;
    tick();
    checks++;
    if (OutValid !== 1'b1 || Pattern !== 4'b0001) begin
      errors++; $display("FAIL mid_reset_next got ov=%b pat=%b exp ov=1 pat=0001", OutValid, Pattern);
    end
    InValid = 0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      Reset    = ($urandom_range(0, 49) == 0);
      InValid  = $urandom_range(0, 3) != 0;
      OutReady = $urandom_range(0, 2) != 0;
      Count    = 3'($urandom_range(0, 7));
      #1;
      checks++;
      if (InReady !== exp_ready()) begin errors++; $display("FAIL rand_ready i=%0d got=%b exp=%b", i, InReady, exp_ready()); end
      tick();
      checks++;
      if (OutValid !== m_ov || Pattern !== m_pat || Error !== m_err || int'(ErrCount) != m_ec) begin
        errors++;
        $display("FAIL rand_out i=%0d got ov=%b pat=%b err=%b ec=%0d exp ov=%b pat=%b err=%b ec=%0d",
                 i, OutValid, Pattern, Error, ErrCount, m_ov, m_pat, m_err, m_ec);
      end
      if (OutValid === 1'b1 && Error === 1'b0 && ones(Pattern) != ones(m_pat)) begin
        errors++; $display("FAIL rand_popcount i=%0d got=%0d exp=%0d", i, ones(Pattern), ones(m_pat));
      end
    end
    Reset = 0; InValid = 0; OutReady = 1;
    tick();
  endtask

  initial begin
    m_ov = 0; m_pat = 4'b0000; m_err = 0; m_ec = 0; m_ptr = 0;
    test_reset();
    test_sweep();
    test_rotation();
    test_backpressure();
    test_illegal();
    test_reset_mid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
